// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multi-cycle MIPS control FSM (master) and the datapath (slave).
// The master drives every datapath control line; the slave returns opcode, zero flag and memory ready.
interface mips_multicycle_ctrl_if #(
  parameter int op_width     = 6,
  parameter int width_alu_op = 2,
  parameter int state_width  = 4
) ();
  logic [op_width-1:0]     op;
  logic                    zero;
  logic                    mem_ready;
  logic [width_alu_op-1:0] alu_op;
  logic                    alu_src_a;
  logic [1:0]              alu_src_b;
  logic                    i_or_d;
  logic                    mem_write;
  logic                    ir_write;
  logic                    reg_write;
  logic                    reg_dst;
  logic                    mem_to_reg;
  logic [1:0]              pc_src;
  logic                    pc_en;
  logic [state_width-1:0]  state;

  modport master (
    input  op, zero, mem_ready,
    output alu_op, alu_src_a, alu_src_b, i_or_d, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, pc_src, pc_en, state
  );

  modport slave (
    output op, zero, mem_ready,
    input  alu_op, alu_src_a, alu_src_b, i_or_d, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, pc_src, pc_en, state
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS core: fetch/decode/execute/memory/writeback sequencing.
// Optional MIPS_CTRL_ILLEGAL_TRAP_EN: unsupported opcodes halt the core in TRAP until reset.
module mips_multicycle_ctrl #(
  parameter int op_width     = 6,
  parameter int width_alu_op = 2,
  parameter int state_width  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  mips_multicycle_ctrl_if.master       bus
);

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  typedef enum logic [state_width-1:0] {
    FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXECUTE = 6,
    ALUWB = 7, BRANCH = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11, TRAP = 12
  } state_t;
`else
  typedef enum logic [state_width-1:0] {
    FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXECUTE = 6,
    ALUWB = 7, BRANCH = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11
  } state_t;
`endif

  localparam logic [op_width-1:0] OP_RTYPE = 6'b000000;
  localparam logic [op_width-1:0] OP_LW    = 6'b100011;
  localparam logic [op_width-1:0] OP_SW    = 6'b101011;
  localparam logic [op_width-1:0] OP_BEQ   = 6'b000100;
  localparam logic [op_width-1:0] OP_ADDI  = 6'b001000;
  localparam logic [op_width-1:0] OP_J     = 6'b000010;

  localparam logic [width_alu_op-1:0] ALU_ADD   = 2'b00;
  localparam logic [width_alu_op-1:0] ALU_SUB   = 2'b01;
  localparam logic [width_alu_op-1:0] ALU_FUNCT = 2'b10;

  state_t state_q, state_d;

  logic [width_alu_op-1:0] alu_op;
  logic                    alu_src_a;
  logic [1:0]              alu_src_b;
  logic                    i_or_d;
  logic                    mem_write;
  logic                    ir_write;
  logic                    reg_write;
  logic                    reg_dst;
  logic                    mem_to_reg;
  logic [1:0]              pc_src;
  logic                    pc_en;

  // NOTE: state is a flop, so it takes non-blocking assignments; the async reset
  // returns to FETCH without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output and the next state get a default first, so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d    = FETCH;
    alu_op     = ALU_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    i_or_d     = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    pc_src     = 2'b00;
    pc_en      = 1'b0;

    case (state_q)
      FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = bus.mem_ready;
        pc_en     = bus.mem_ready;
        state_d   = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        // Branch target PC + (imm << 2) is precomputed here into ALUOut.
        alu_src_b = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
          default:      state_d = TRAP;
`else
          default:      state_d = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (bus.op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        i_or_d  = 1'b1;
        state_d = bus.mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        state_d   = bus.mem_ready ? FETCH : MEMWR;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = 2'b01;
        pc_en     = bus.zero;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
      end
      JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      TRAP: begin
        state_d = TRAP;
      end
`endif
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign bus.alu_op     = alu_op;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.i_or_d     = i_or_d;
  assign bus.mem_write  = mem_write;
  assign bus.ir_write   = ir_write;
  assign bus.reg_write  = reg_write;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.pc_src     = pc_src;
  assign bus.pc_en      = pc_en;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: each instruction is expanded into its expected per-cycle trace
// (state, inputs to drive, control outputs) from the instruction flows, then replayed against the DUT.
module tb_mips_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0]  st;
    logic        mr;
    logic        z;
    logic [13:0] o;
  } step_t;

  step_t q[$];

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Packed order: alu_op, alu_src_a, alu_src_b, i_or_d, mem_write, ir_write,
  // reg_write, reg_dst, mem_to_reg, pc_src, pc_en
  function automatic logic [13:0] mk(input int alu, input int a, input int b, input int iord,
                                     input int mw, input int irw, input int rw, input int rd,
                                     input int m2r, input int pcs, input int pce);
    return {alu[1:0], a[0], b[1:0], iord[0], mw[0], irw[0], rw[0], rd[0], m2r[0], pcs[1:0], pce[0]};
  endfunction

  function automatic logic [13:0] outs();
    return {bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.i_or_d, bus.mem_write, bus.ir_write,
            bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.pc_src, bus.pc_en};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit is_legal(input logic [5:0] o);
    return o inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
  endfunction

  task automatic add(input int st, input logic mr, input logic z, input logic [13:0] o);
    step_t s;
    s.st = 4'(st);
    s.mr = mr;
    s.z  = z;
    s.o  = o;
    q.push_back(s);
  endtask

  // Expected trace of one instruction: fw fetch wait cycles, mw memory wait cycles,
  // zb = 0/1 forces the zero flag in BRANCH, -1 randomizes it.
  task automatic build(input logic [5:0] o, input int fw, input int mw, input int zb);
    logic z;
    q.delete();
    for (int i = 0; i < fw; i++) add(0, 1'b0, rb(), mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1'b1, rb(), mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1));
    add(1, rb(), rb(), mk(0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0));
    case (o)
      OP_R: begin
        add(6, rb(), rb(), mk(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(7, rb(), rb(), mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
      end
      OP_LW: begin
        add(2, rb(), rb(), mk(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < mw; i++) add(3, 1'b0, rb(), mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        add(3, 1'b1, rb(), mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        add(4, rb(), rb(), mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
      end
      OP_SW: begin
        add(2, rb(), rb(), mk(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < mw; i++) add(5, 1'b0, rb(), mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        add(5, 1'b1, rb(), mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
      end
      OP_BEQ: begin
        z = (zb < 0) ? rb() : zb[0];
        add(8, rb(), z, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, int'(z)));
      end
      OP_ADDI: begin
        add(9, rb(), rb(), mk(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
        add(10, rb(), rb(), mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      end
      OP_J: add(11, rb(), rb(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1));
      default: begin
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) add(12, rb(), rb(), 14'd0);
`endif
      end
    endcase
  endtask

  // Entered at posedge+1; leaves at the next posedge+1, or at posedge+4 when stopping early.
  task automatic replay(input string tag, input int stop_state, output bit stopped);
    stopped = 1'b0;
    foreach (q[i]) begin
      bus.mem_ready = q[i].mr;
      bus.zero      = q[i].z;
      #3;
      check($sformatf("%s[%0d] state", tag, i), 32'(bus.state), 32'(q[i].st));
      check($sformatf("%s[%0d] outs st%0d", tag, i, q[i].st), 32'(outs()), 32'(q[i].o));
      if (stop_state >= 0 && int'(q[i].st) == stop_state) begin
        stopped = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Entered at posedge+4: asynchronous reset between clock edges, then release.
  task automatic mid_reset(input string tag);
    #1;
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    check({tag, " rst state"}, 32'(bus.state), 32'd0);
    check({tag, " rst mem_write"}, 32'(bus.mem_write), 32'd0);
    check({tag, " rst outs"}, 32'(outs()), 32'(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
    bus.mem_ready = 1'b1;
    #1;
    check({tag, " rst gated outs"}, 32'(outs()), 32'(mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1)));
    @(posedge clk);
    #1;
    check({tag, " rst held"}, 32'(bus.state), 32'd0);
    bus.mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    check({tag, " post i_or_d"}, 32'(bus.i_or_d), 32'd0);
    check({tag, " post alu_src_b"}, 32'(bus.alu_src_b), 32'd1);
  endtask

  task automatic run_instr(input string tag, input logic [5:0] o, input int fw, input int mw,
                           input int zb);
    bit stopped;
    bus.op = o;
    build(o, fw, mw, zb);
    replay(tag, -1, stopped);
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    if (!is_legal(o)) begin
      #3;
      mid_reset({tag, " trap"});
    end
`endif
  endtask

  initial begin
    bit stopped;
    logic [5:0] o;
    rst_n = 1'b0;
    bus.op = 6'd0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    #2;
    check("reset state", 32'(bus.state), 32'd0);
    check("reset outs mr0", 32'(outs()), 32'(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
    bus.mem_ready = 1'b1;
    #1;
    check("reset outs mr1", 32'(outs()), 32'(mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1)));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_instr("rtype", OP_R, 0, 0, -1);
    run_instr("lw_wait", OP_LW, 0, 3, -1);
    run_instr("beq_taken", OP_BEQ, 0, 0, 1);
    run_instr("beq_not", OP_BEQ, 0, 0, 0);
    run_instr("fetch_stall", OP_ADDI, 2, 0, -1);
    run_instr("jump", OP_J, 0, 0, -1);
    run_instr("sw", OP_SW, 1, 2, -1);
    run_instr("illegal", 6'b111111, 0, 0, -1);

    bus.op = OP_SW;
    build(OP_SW, 0, 4, -1);
    replay("sw_mid", 5, stopped);
    check("sw_mid reached MEMWR", 32'(stopped), 32'd1);
    mid_reset("sw_mid");
    @(posedge clk);
    #1;
    run_instr("after_rst", OP_R, 0, 0, -1);

    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 6))
        0: o = OP_R;
        1: o = OP_LW;
        2: o = OP_SW;
        3: o = OP_BEQ;
        4: o = OP_ADDI;
        5: o = OP_J;
        default: begin
          o = 6'($urandom);
          while (is_legal(o)) o = 6'($urandom);
        end
      endcase
      run_instr($sformatf("rnd%0d", n), o, $urandom_range(0, 2), $urandom_range(0, 3), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle MIPS core variant.
- Drives the 2-bit alu_op consumed by the existing ALU function decoder:
  - 00 = add
  - 01 = subtract
  - 10 = decode from funct field
- Decodes the 6-bit opcode held in the instruction register and sequences fetch, decode, execute, memory and writeback over multiple cycles.
- Stalls on a simple memory ready handshake.

Parameters:
- op_width, 6, opcode field width
- width_alu_op, 2, width of alu_op output
- state_width, 4, state register width

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- op  input  op_width  opcode from instruction register (instr[31:26]), valid from DECODE onward
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completed current access this cycle
- alu_op  output  width_alu_op  to ALU decoder
- alu_src_a  output  1  0 = PC, 1 = register A
- alu_src_b  output  2  00 = reg B, 01 = constant 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- i_or_d  output  1  memory address: 0 = PC, 1 = ALUOut
- mem_write  output  1  memory write request
- ir_write  output  1  load instruction register
- reg_write  output  1  register file write enable
- reg_dst  output  1  0 = rt, 1 = rd
- mem_to_reg  output  1  0 = ALUOut, 1 = memory data
- pc_src  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- pc_en  output  1  PC load enable
- state  output  state_width  current state, for debug/trace

Behaviour:
- Supported opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - addi 001000
  - j 000010
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, TRAP=12 (TRAP only with the optional feature).
- Reset: rst_n low forces state=FETCH immediately, independent of clk, including mid-operation. All outputs then take FETCH values, with ir_write and pc_en gated by mem_ready.
- Output defaults: every output not listed for a state is 0, including alu_op=00 and pc_src=00.
- Outputs are Moore decodes of state, except the Mealy terms:
  - FETCH: ir_write and pc_en
  - BRANCH: pc_en
- FETCH:
  - i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00
  - ir_write=mem_ready, pc_en=mem_ready
  - stay while mem_ready=0; go to DECODE when mem_ready=1
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by op:
  - lw/sw -> MEMADR
  - R-type -> EXECUTE
  - beq -> BRANCH
  - addi -> ADDIEX
  - j -> JUMP
  - other -> FETCH (instruction treated as NOP)
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: i_or_d=1. Hold until mem_ready=1, then MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Next: FETCH.
- MEMWR: i_or_d=1, mem_write=1. mem_write stays asserted every cycle until mem_ready=1, then FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Next: ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero. Next: FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next: ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Next: FETCH.
- JUMP: pc_src=10, pc_en=1. Next: FETCH.
- Unreachable state encodings: next state FETCH, all outputs 0.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- Cycle counts with zero wait states:
  - R-type 4
  - lw 5
  - sw 4
  - beq 3
  - addi 4
  - j 3

Optional Feature:
- Macro: MIPS_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - an unsupported opcode in DECODE goes to TRAP
  - TRAP drives all outputs 0 and state=12
  - TRAP holds until rst_n asserts; the core halts
- Undefined: TRAP does not exist; an unsupported opcode returns DECODE -> FETCH (NOP).

Test Plan:
- Reset mid-MEMWR: drop rst_n asynchronously while mem_write=1 -> state=0 and mem_write=0 before the next clk edge; after release, FETCH with i_or_d=0, alu_src_b=01.
- R-type, op=000000, mem_ready=1 -> states 0,1,6,7,0; alu_op=10 in EXECUTE; reg_write=1 and reg_dst=1 in ALUWB; exactly 4 cycles.
- lw, op=100011, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles with i_or_d=1; then MEMWB with reg_write=1, mem_to_reg=1; total 8 cycles.
- beq, op=000100:
  - zero=1 -> in BRANCH pc_en=1, pc_src=01, alu_op=01
  - zero=0 -> pc_en=0
  - both cases return to FETCH after 3 cycles
- FETCH stall: mem_ready=0 for 2 cycles -> ir_write=0 and pc_en=0, state stays 0; then mem_ready=1 -> ir_write=1, pc_en=1, DECODE next.
- op=111111 (unsupported):
  - without macro -> sequence 0,1,0
  - with MIPS_CTRL_ILLEGAL_TRAP_EN -> state=12 held 10 cycles, all outputs 0, leaves TRAP only on rst_n low
